alpha_u_accum: RTL and testbench
================================

Name: alpha_u_accum

Overview:
- Upstream neighbour of the x-initial decision stage.
- Sums I per-check-node messages for every (user j, symbol hypothesis a) into alpha_u.
- Streams the result out one column per hypothesis: alpha_u_col / tvalid / tlast.
- The output stream is exactly what the per-lane argmax stage consumes: A beats per frame, tlast on the last beat.

Parameters:
- J, 14, number of lanes (users); each lane carries a 64-bit value.
- I, 7, number of messages summed per (j,a).
- A, 2, hypotheses per frame; equals output beats per frame.
- IW, $clog2(I)+1 (localparam), width of message counter.
- AW, $clog2(A)+1 (localparam), width of hypothesis counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- msg_col  in  J*64  lane j at [j*64+:64]; signed two's-complement message.
- msg_col_tvalid  in  1  input beat valid.
- msg_col_tlast  in  1  asserted on the final beat of a frame (beat A*I-1).
- alpha_u_col  out  J*64  lane j at [j*64+:64]; saturated signed sum.
- alpha_u_col_tvalid  out  1  output beat valid, one cycle per column.
- alpha_u_col_tlast  out  1  asserted with the beat for a = A-1.
- frame_err  out  1  sticky; set on tlast position mismatch; cleared only by rst.

Behaviour:
- Input order per frame: a outer (0..A-1), i inner (0..I-1). Total A*I valid beats. Gaps (tvalid low) are allowed anywhere; no backpressure.
- Counters i_cnt (0..I-1) and a_cnt (0..A-1) advance only on valid beats. i_cnt wraps I-1 -> 0 and then increments a_cnt. a_cnt wraps A-1 -> 0.
- Accumulation, per lane, per valid beat:
  - i_cnt==0: acc <= msg.
  - otherwise: acc <= sat(acc + msg).
  - sat: compute a 65-bit sum and clamp to [-2^63, 2^63-1].
- Emit: on the valid beat with i_cnt==I-1, the next cycle shows:
  - alpha_u_col = final sum, including this beat's message.
  - tvalid = 1.
  - tlast = (a_cnt==A-1).
- Latency is exactly 1 cycle from the last message beat of a column. tvalid is a single-cycle pulse.
- alpha_u_col holds its value between pulses. It does not change on non-emit cycles.
- The output column is registered separately from acc, so column a+1 may begin the cycle after column a's last beat with no bubble.
- State: IDLE (i_cnt==0 && a_cnt==0) and ACCUM (otherwise); the counters encode the state.
  - IDLE -> ACCUM on the first valid beat.
  - ACCUM -> IDLE after the valid beat with i_cnt==I-1 && a_cnt==A-1.
- tlast checking:
  - msg_col_tlast high on a beat not at (I-1, A-1), or low on the beat at (I-1, A-1): set frame_err.
  - Counters still follow beat counting; tlast never resyncs them.
  - The output stream is still produced.
- rst, including mid-frame:
  - counters -> 0, acc -> 0, alpha_u_col -> 0, alpha_u_col_tvalid -> 0, alpha_u_col_tlast -> 0, frame_err -> 0.
  - A partial frame is discarded; the next valid beat is treated as (i=0, a=0).
- I==1: every valid beat emits a column (degenerate case, legal).
- A==1: every emitted column has tlast=1.

Decomposition:
- Shared package alpha_pkg:
  - LANE_W = 64.
  - SAT_MAX / SAT_MIN constants.
  - Function sat_add64(a, b) returning the clamped 64-bit sum.
- Sub-module lane_sat_acc:
  - One instance per lane in a generate loop.
  - Ports: clk, rst, din, load, en, acc_out.
  - Holds the accumulator and the saturating adder.
- Counters, tlast check and output registers live in the top level.

Test Plan:
- Nominal (J=14, I=7, A=2), lane j message = j+1 for all beats, no gaps -> column 0 lane j = 7*(j+1) at cycle 8 after the first beat with tvalid=1, tlast=0; column 1 identical with tlast=1 seven cycles later; frame_err=0.
- Random tvalid gaps (~50% duty), messages lane0 = i - 3 for a=0 and 100*i for a=1 -> exactly two output pulses, lane0 = 0 then 2100; alpha_u_col unchanged between pulses.
- Saturation: lane0 messages all 2^62 -> lane0 = 0x7FFF_FFFF_FFFF_FFFF; lane1 messages all -2^62 -> lane1 = 0x8000_0000_0000_0000; other lanes unaffected.
- tlast at beat 5 of a 14-beat frame -> frame_err rises the next cycle and stays 1; both columns still emitted, second with tlast=1.
- rst pulsed after 9 beats -> all outputs 0 next cycle; a fresh 14-beat frame yields correct sums with no residue from the aborted frame.
- Back-to-back frames with no idle cycle -> 4 output pulses; tlast pattern 0,1,0,1; second frame's sums independent of the first.

Source files
------------

// File: rtl/alpha_pkg.sv
// Shared definitions for the alpha_u accumulator.
//   LANE_W     : width of one lane value (signed two's complement)
//   SAT_MAX/MIN: clamp bounds for a signed LANE_W value
//   sat_add64  : signed add of two lane values, clamped instead of wrapping
package alpha_pkg;

  localparam int LANE_W = 64;

  localparam logic [LANE_W-1:0] SAT_MAX = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] SAT_MIN = {1'b1, {(LANE_W-1){1'b0}}};

  // One guard bit is enough: overflow shows up as the guard bit
  // disagreeing with the lane sign bit, and the guard bit gives the direction.
  function automatic logic [LANE_W-1:0] sat_add64(input logic [LANE_W-1:0] a,
                                                  input logic [LANE_W-1:0] b);
    logic [LANE_W:0] s;
    s = {a[LANE_W-1], a} + {b[LANE_W-1], b};
    if (s[LANE_W] != s[LANE_W-1])
      return s[LANE_W] ? SAT_MIN : SAT_MAX;
    return s[LANE_W-1:0];
  endfunction

endpackage

// File: rtl/lane_sat_acc.sv
// Per-lane saturating accumulator.
//   clk, rst : clock, synchronous active-high reset
//   din      : signed message for this lane
//   load     : first message of a column, start a fresh sum
//   en       : beat valid, update the accumulator
//   acc_out  : sum including the current din (next accumulator value), so the
//              parent can capture the finished column on its last beat
module lane_sat_acc
  import alpha_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [LANE_W-1:0] din,
  input  logic              load,
  input  logic              en,
  output logic [LANE_W-1:0] acc_out
);

  logic [LANE_W-1:0] acc;

  assign acc_out = load ? din : sat_add64(acc, din);

  always_ff @(posedge clk) begin
    if (rst)     acc <= '0;
    else if (en) acc <= acc_out;
  end

endmodule

// File: rtl/alpha_u_accum.sv
// Sums I messages per (user j, hypothesis a) and streams one column of J
// saturated sums per hypothesis, A beats per frame.
//   clk, rst           : clock, synchronous active-high reset
//   msg_col/_tvalid/_tlast : input beats, a outer / i inner, A*I per frame
//   alpha_u_col/_tvalid/_tlast : output column, one-cycle pulse per column,
//                        tlast on a = A-1; data holds between pulses
//   frame_err          : sticky, input tlast seen at the wrong beat
module alpha_u_accum
  import alpha_pkg::*;
#(
  parameter int J = 14,
  parameter int I = 7,
  parameter int A = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [J*LANE_W-1:0] msg_col,
  input  logic                msg_col_tvalid,
  input  logic                msg_col_tlast,
  output logic [J*LANE_W-1:0] alpha_u_col,
  output logic                alpha_u_col_tvalid,
  output logic                alpha_u_col_tlast,
  output logic                frame_err
);

  localparam int IW = $clog2(I) + 1;
  localparam int AW = $clog2(A) + 1;

  // Counters double as the state: both zero is IDLE, anything else ACCUM.
  logic [IW-1:0] i_cnt;
  logic [AW-1:0] a_cnt;

  logic last_i, last_a;
  assign last_i = (i_cnt == IW'(I-1));
  assign last_a = (a_cnt == AW'(A-1));

  logic [J-1:0][LANE_W-1:0] msg_lane, acc_nxt;
  assign msg_lane = msg_col;

  for (genvar j = 0; j < J; j++) begin : g_lane
    lane_sat_acc u_acc (
      .clk    (clk),
      .rst    (rst),
      .din    (msg_lane[j]),
      .load   (i_cnt == '0),
      .en     (msg_col_tvalid),
      .acc_out(acc_nxt[j])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_cnt              <= '0;
      a_cnt              <= '0;
      alpha_u_col        <= '0;
      alpha_u_col_tvalid <= 1'b0;
      alpha_u_col_tlast  <= 1'b0;
      frame_err          <= 1'b0;
    end else begin
      alpha_u_col_tvalid <= 1'b0;
      alpha_u_col_tlast  <= 1'b0;
      if (msg_col_tvalid) begin
        // tlast is only checked, never used to realign the counters
        if (msg_col_tlast != (last_i && last_a)) frame_err <= 1'b1;
        if (last_i) begin
          i_cnt              <= '0;
          a_cnt              <= last_a ? '0 : a_cnt + AW'(1);
          // separate output register lets the next column start immediately
          alpha_u_col        <= acc_nxt;
          alpha_u_col_tvalid <= 1'b1;
          alpha_u_col_tlast  <= last_a;
        end else begin
          i_cnt <= i_cnt + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alpha_u_accum.sv
module tb_alpha_u_accum;

  localparam int J = 14;
  localparam int I = 7;
  localparam int A = 2;
  localparam int W = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [J*W-1:0]   msg_col = '0;
  logic             msg_col_tvalid = 1'b0;
  logic             msg_col_tlast = 1'b0;
  logic [J*W-1:0]   alpha_u_col;
  logic             alpha_u_col_tvalid;
  logic             alpha_u_col_tlast;
  logic             frame_err;

  alpha_u_accum #(.J(J), .I(I), .A(A)) dut (
    .clk               (clk),
    .rst               (rst),
    .msg_col           (msg_col),
    .msg_col_tvalid    (msg_col_tvalid),
    .msg_col_tlast     (msg_col_tlast),
    .alpha_u_col       (alpha_u_col),
    .alpha_u_col_tvalid(alpha_u_col_tvalid),
    .alpha_u_col_tlast (alpha_u_col_tlast),
    .frame_err         (frame_err)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;
  int cyc  = 0;

  typedef struct {
    logic [J*W-1:0] col;
    logic           last;
    int             due;
  } exp_t;
  exp_t q[$];

  // reference model: running per-lane sums in wide arithmetic, clamped each step
  logic signed [127:0] m_acc [J];
  int                  m_i, m_a;
  bit                  m_err;
  bit                  exp_err_q;
  logic [J*W-1:0]      exp_hold;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s act=%h exp=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic signed [127:0] clamp(input logic signed [127:0] v);
    logic signed [127:0] hi, lo;
    hi = 128'sh7FFF_FFFF_FFFF_FFFF;
    lo = -(128'sh8000_0000_0000_0000);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic signed [127:0] sx(input logic [63:0] m);
    return {{64{m[63]}}, m};
  endfunction

  always @(posedge clk) begin
    cyc++;
    exp_err_q = m_err;
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (alpha_u_col_tvalid) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("pulse_cycle", 64'(cyc), 64'(e.due));
          chk("col_tlast", {63'd0, alpha_u_col_tlast}, {63'd0, e.last});
          for (int j = 0; j < J; j++)
            chk($sformatf("col_lane%0d", j), alpha_u_col[j*W +: W], e.col[j*W +: W]);
          exp_hold = e.col;
        end
      end else begin
        if (q.size() != 0 && q[0].due <= cyc) begin
          chk("missing_pulse", 64'd0, 64'd1);
          void'(q.pop_front());
        end
        if (alpha_u_col !== exp_hold) begin
          for (int j = 0; j < J; j++)
            chk($sformatf("hold_lane%0d", j), alpha_u_col[j*W +: W], exp_hold[j*W +: W]);
        end else begin
          ncmp++;
        end
        chk("tlast_idle", {63'd0, alpha_u_col_tlast}, 64'd0);
      end
      chk("frame_err", {63'd0, frame_err}, {63'd0, exp_err_q});
    end
  end

  task automatic model_reset();
    for (int j = 0; j < J; j++) m_acc[j] = '0;
    m_i = 0; m_a = 0; m_err = 0;
  endtask

  task automatic idle();
    msg_col_tvalid = 1'b0;
    msg_col_tlast  = 1'b0;
    @(posedge clk); #1;
  endtask

  // drive one valid beat and advance the model by it
  task automatic beat(input logic [J*W-1:0] m, input logic tl);
    exp_t e;
    msg_col = m; msg_col_tvalid = 1'b1; msg_col_tlast = tl;
    if (tl != (m_i == I-1 && m_a == A-1)) m_err = 1;
    for (int j = 0; j < J; j++)
      m_acc[j] = (m_i == 0) ? sx(m[j*W +: W]) : clamp(m_acc[j] + sx(m[j*W +: W]));
    if (m_i == I-1) begin
      for (int j = 0; j < J; j++) e.col[j*W +: W] = m_acc[j][63:0];
      e.last = (m_a == A-1);
      e.due  = cyc + 1;
      q.push_back(e);
      m_i = 0;
      m_a = (m_a + 1) % A;
    end else begin
      m_i++;
    end
    @(posedge clk); #1;
    msg_col_tvalid = 1'b0;
    msg_col_tlast  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    model_reset();
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_hold = '0;
    chk("rst_col", {63'd0, |alpha_u_col}, 64'd0);
    chk("rst_tvalid", {63'd0, alpha_u_col_tvalid}, 64'd0);
    chk("rst_tlast", {63'd0, alpha_u_col_tlast}, 64'd0);
    chk("rst_frame_err", {63'd0, frame_err}, 64'd0);
  endtask

  function automatic logic [63:0] rnd_small();
    int v;
    v = int'($urandom_range(2000)) - 1000;
    return 64'(signed'(v));
  endfunction

  // mode 0: lane j = j+1; 1: lane0 i-3 / 100*i; 2: saturation; 3: full random
  task automatic run_frame(input int mode, input int gap_pct, input int bad_beat,
                           input int stop_after);
    logic [J*W-1:0] m;
    int ii, aa;
    for (int b = 0; b < A*I; b++) begin
      if (b == stop_after) return;
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) idle();
      ii = b % I; aa = b / I;
      for (int j = 0; j < J; j++) begin
        case (mode)
          0: m[j*W +: W] = 64'(j + 1);
          1: m[j*W +: W] = rnd_small();
          2: m[j*W +: W] = rnd_small();
          default: m[j*W +: W] = {$urandom(), $urandom()};
        endcase
      end
      if (mode == 1) m[0 +: W] = (aa == 0) ? 64'(signed'(ii - 3)) : 64'(100 * ii);
      if (mode == 2) begin
        m[0 +: W] = 64'h4000_0000_0000_0000;
        m[W +: W] = 64'hC000_0000_0000_0000;
      end
      beat(m, (b == A*I-1) ^ (b == bad_beat));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    exp_hold = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    run_frame(0, 0, -1, -1);                 // nominal
    repeat (3) idle();
    run_frame(1, 50, -1, -1);                // gaps, known lane0 sums 0 / 2100
    repeat (3) idle();
    run_frame(2, 20, -1, -1);                // saturation both directions
    repeat (3) idle();
    run_frame(3, 30, 5, -1);                 // misplaced tlast
    repeat (3) idle();
    chk("frame_err_sticky", {63'd0, frame_err}, 64'd1);
    run_frame(0, 0, -1, -1);                 // error stays set on a clean frame
    repeat (2) idle();
    chk("frame_err_still", {63'd0, frame_err}, 64'd1);

    run_frame(3, 0, -1, 9);                  // aborted frame
    do_reset();
    run_frame(1, 0, -1, -1);                 // fresh frame after abort
    run_frame(3, 0, -1, -1);                 // back-to-back frames
    run_frame(0, 0, -1, -1);
    run_frame(2, 0, -1, -1);
    for (int k = 0; k < 6; k++) run_frame(3, int'($urandom_range(60)), -1, -1);

    repeat (4) idle();
    chk("queue_drained", 64'(q.size()), 64'd0);
    chk("frame_err_end", {63'd0, frame_err}, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
